spi_flash_bulk_erase: RTL and testbench
=======================================

// Module: spi_flash_bulk_erase
// PURPOSE
//  - Button-triggered SPI master that bulk-erases an M25P16-class serial NOR flash.
//  - Each touch_key press sends WRITE ENABLE (0x06), releases cs_n, then sends BULK ERASE (0xC7).
//  - Sits between the board touch key and the flash pins; transmit-only, no MISO, no status polling.
// PARAMETERS
//  CLK_DIV       4      sys_clk cycles per sck period; even, >=2; 50 MHz -> 12.5 MHz sck
//  CS_SETUP_CYC  2      sys_clk cycles with cs_n low before the first sck rise of a command
//  CS_HOLD_CYC   2      sys_clk cycles with cs_n low after the last sck fall of a command
//  CS_GAP_CYC    8      sys_clk cycles with cs_n high between WREN and BE (>=100 ns tSHSL)
//  CMD_WREN      8'h06  write-enable opcode
//  CMD_BE        8'hC7  bulk-erase opcode
// PORTS
//  sys_clk    in   1  system clock, 50 MHz
//  rst_n      in   1  reset; synchronous, active-low
//  touch_key  in   1  asynchronous key input, idle high, pressed = low
//  MOSI       out  1  serial command data, MSB first
//  cs_n       out  1  flash chip select, active-low
//  sck        out  1  SPI serial clock, mode 0 (idle low)
// BEHAVIOUR
//  - Reset: on a sys_clk edge with rst_n=0: cs_n=1, sck=0, MOSI=0, FSM=IDLE, counters=0. Applies mid-command too; the partial command is abandoned (the flash ignores it because cs_n rises off a byte boundary).
//  - Key: 2-FF synchronizer, then falling-edge detect (sync_prev=1 & sync=0) -> one-cycle trigger.
//  - Holding the key low gives one trigger; it must go high and low again to retrigger.
//  - Triggers outside IDLE are dropped, not queued; a busy sequence is never interrupted.
//  - FSM: IDLE -> WREN_SETUP -> WREN_TX -> WREN_HOLD -> GAP -> BE_SETUP -> BE_TX -> BE_HOLD -> IDLE.
//  - Trigger taken in IDLE: cs_n goes low on the next edge (entering WREN_SETUP).
//  - Latency: cs_n falls at most 4 sys_clk edges after the first edge that samples touch_key=0.
//  - SETUP/HOLD/GAP: each lasts exactly its parameter in cycles. cs_n is high only in GAP and IDLE.
//  - TX: 8 bits MSB first, CLK_DIV cycles per bit.
//    - MOSI changes only while sck is low, at the start of each bit.
//    - sck is low for the first CLK_DIV/2 cycles of each bit and high for the second half.
//    - The flash samples MOSI on the sck rise.
//  - After bit 0, sck returns low, then the HOLD state begins.
//  - Exactly 8 sck rising edges per cs_n-low window. sck=0 whenever cs_n=1. MOSI=0 in IDLE/GAP.
//  - With defaults, one full sequence lasts 36 + 8 + 36 = 80 cycles (1.6 us) of cs_n activity, then IDLE.
//  - The controller does not wait for erase completion. A later press simply re-issues WREN+BE; the flash ignores it while erase is in progress.
// CONFIGURATION
//  - KEY_DEBOUNCE_EN defined:
//    - The synchronized key must read a new level for DEBOUNCE_CYC consecutive cycles before the debounced level changes.
//    - DEBOUNCE_CYC is a localparam, 20 ms = 1_000_000 at 50 MHz.
//    - Edge detect operates on the debounced level; latency grows by DEBOUNCE_CYC.
//  - KEY_DEBOUNCE_EN undefined: no debounce; any synchronized falling edge triggers (simulation default).
// STRUCTURE
//  - Package flash_spi_pkg: opcode constants (CMD_WREN, CMD_BE, plus READ/PP/SE/RDSR for sibling blocks) and the FSM state encoding.
//  - Sub-module spi_byte_tx: inputs start + byte; outputs sck, MOSI, done.
//    - done is a one-cycle pulse after the last sck fall.
//    - Generates the CLK_DIV bit timing; instantiated once and reused for both commands.
//  - Top level: synchronizer, edge detect, optional debounce, sequencing FSM, cs_n and timing counters.
// TESTING
//  - Release rst_n at 20 ns; press at 520 ns for 500 ns:
//    - first window shifts 0x06 (8 sck rises, bits 0,0,0,0,0,1,1,0);
//    - cs_n high >= 8 cycles;
//    - second window shifts 0xC7;
//    - then cs_n=1, sck=0.
//  - Second press at ~1.8 us while the sequence is active:
//    - dropped; exactly two cs_n-low windows in total, unchanged.
//  - Third press at ~47 us, after completion: a new WREN+BE pair is emitted, identical timing.
//  - Key held low for 10 us: exactly one sequence.
//  - rst_n pulsed low mid-WREN_TX: cs_n=1, sck=0 on that edge; no further activity until the next press.
//  - Flash model with w=1, hold=1: WEL set after the first window; erase (WIP=1) starts at the cs_n rise after 0xC7; mode-0 timing checks pass at 12.5 MHz.

Source files
------------

// File: rtl/flash_spi_pkg.sv
// Shared SPI NOR flash definitions: M25P16-class opcodes and the bulk-erase sequencer state encoding.
package flash_spi_pkg;

  localparam logic [7:0] CMD_WREN = 8'h06;
  localparam logic [7:0] CMD_BE   = 8'hC7;
  localparam logic [7:0] CMD_READ = 8'h03;
  localparam logic [7:0] CMD_PP   = 8'h02;
  localparam logic [7:0] CMD_SE   = 8'hD8;
  localparam logic [7:0] CMD_RDSR = 8'h05;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WREN_SETUP = 3'd1,
    ST_WREN_TX    = 3'd2,
    ST_WREN_HOLD  = 3'd3,
    ST_GAP        = 3'd4,
    ST_BE_SETUP   = 3'd5,
    ST_BE_TX      = 3'd6,
    ST_BE_HOLD    = 3'd7
  } state_t;

endpackage

// File: rtl/spi_byte_tx.sv
// SPI mode-0 byte shifter: MSB first, CLK_DIV sys_clk cycles per bit, done pulses after the last sck fall.
module spi_byte_tx #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       sck,
  output logic       MOSI,
  output logic       done
);

  localparam int unsigned DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] HALF_LAST = DW'(CLK_DIV / 2 - 1);
  localparam logic [DW-1:0] BIT_LAST  = DW'(CLK_DIV - 1);

  logic          busy;
  logic [DW-1:0] div_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy    <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      sck     <= 1'b0;
      MOSI    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!busy) begin
        if (start) begin
          busy    <= 1'b1;
          div_cnt <= '0;
          bit_cnt <= 3'd7;
          shreg   <= {data[6:0], 1'b0};
          MOSI    <= data[7];
          sck     <= 1'b0;
        end
      end else begin
        if (div_cnt == HALF_LAST) sck <= 1'b1;
        if (div_cnt == BIT_LAST) begin
          // sck falls and MOSI advances on the same edge, so MOSI only moves while sck is low
          div_cnt <= '0;
          sck     <= 1'b0;
          if (bit_cnt == 3'd0) begin
            busy <= 1'b0;
            done <= 1'b1;
            MOSI <= 1'b0;
          end else begin
            bit_cnt <= bit_cnt - 3'd1;
            MOSI    <= shreg[7];
            shreg   <= {shreg[6:0], 1'b0};
          end
        end else begin
          div_cnt <= div_cnt + DW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/spi_flash_bulk_erase.sv
// Touch-key triggered WREN + BULK ERASE sequencer for an SPI NOR flash.
// Define KEY_DEBOUNCE_EN to debounce the key for 20 ms before edge detection.
module spi_flash_bulk_erase
  import flash_spi_pkg::*;
#(
  parameter int unsigned CLK_DIV      = 4,
  parameter int unsigned CS_SETUP_CYC = 2,
  parameter int unsigned CS_HOLD_CYC  = 2,
  parameter int unsigned CS_GAP_CYC   = 8,
  parameter logic [7:0]  CMD_WREN     = flash_spi_pkg::CMD_WREN,
  parameter logic [7:0]  CMD_BE       = flash_spi_pkg::CMD_BE
) (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic touch_key,
  output logic MOSI,
  output logic cs_n,
  output logic sck
);

  localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP_CYC - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(CS_HOLD_CYC - 1);
  localparam logic [7:0] GAP_LAST   = 8'(CS_GAP_CYC - 1);

  logic key_s1, key_s2, key_level, key_prev, trig;

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      key_s1 <= 1'b1;
      key_s2 <= 1'b1;
    end else begin
      key_s1 <= touch_key;
      key_s2 <= key_s1;
    end
  end

`ifdef KEY_DEBOUNCE_EN
  localparam int unsigned DEBOUNCE_CYC = 1_000_000;
  logic [19:0] deb_cnt;
  logic        key_deb;

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      deb_cnt <= '0;
      key_deb <= 1'b1;
    end else if (key_s2 != key_deb) begin
      if (deb_cnt == 20'(DEBOUNCE_CYC - 1)) begin
        deb_cnt <= '0;
        key_deb <= key_s2;
      end else begin
        deb_cnt <= deb_cnt + 20'd1;
      end
    end else begin
      deb_cnt <= '0;
    end
  end

  assign key_level = key_deb;
`else
  assign key_level = key_s2;
`endif

  always_ff @(posedge sys_clk) begin
    if (!rst_n) key_prev <= 1'b1;
    else        key_prev <= key_level;
  end

  assign trig = key_prev & ~key_level;

  state_t     state;
  logic [7:0] cnt;
  logic       tx_start, tx_done;
  logic [7:0] tx_byte;

  assign tx_start = ((state == ST_WREN_SETUP) || (state == ST_BE_SETUP)) && (cnt == SETUP_LAST);
  assign tx_byte  = (state == ST_BE_SETUP) ? CMD_BE : CMD_WREN;

  spi_byte_tx #(.CLK_DIV(CLK_DIV)) u_tx (
    .clk   (sys_clk),
    .rst_n (rst_n),
    .start (tx_start),
    .data  (tx_byte),
    .sck   (sck),
    .MOSI  (MOSI),
    .done  (tx_done)
  );

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      cs_n  <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: if (trig) begin
          state <= ST_WREN_SETUP;
          cs_n  <= 1'b0;
          cnt   <= '0;
        end
        ST_WREN_SETUP, ST_BE_SETUP: begin
          if (cnt == SETUP_LAST) begin
            state <= (state == ST_WREN_SETUP) ? ST_WREN_TX : ST_BE_TX;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        // The done cycle already has sck low, so it counts as the first hold cycle
        ST_WREN_TX, ST_BE_TX: if (tx_done) begin
          state <= (state == ST_WREN_TX) ? ST_WREN_HOLD : ST_BE_HOLD;
          cnt   <= 8'd1;
        end
        ST_WREN_HOLD, ST_BE_HOLD: begin
          if (cnt >= HOLD_LAST) begin
            state <= (state == ST_WREN_HOLD) ? ST_GAP : ST_IDLE;
            cs_n  <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ST_GAP: begin
          if (cnt == GAP_LAST) begin
            state <= ST_BE_SETUP;
            cs_n  <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
          cs_n  <= 1'b1;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_bulk_erase.sv
// Scoreboard bench for spi_flash_bulk_erase: each cs_n-low window is decoded and matched against queued expectations.
`timescale 1ns/1ps
module tb_spi_flash_bulk_erase;

  logic sys_clk = 1'b0;
  logic rst_n = 1'b0;
  logic touch_key = 1'b1;
  logic MOSI, cs_n, sck;

  spi_flash_bulk_erase #(
    .CLK_DIV      (4),
    .CS_SETUP_CYC (2),
    .CS_HOLD_CYC  (2),
    .CS_GAP_CYC   (8),
    .CMD_WREN     (8'h06),
    .CMD_BE       (8'hC7)
  ) dut (
    .sys_clk   (sys_clk),
    .rst_n     (rst_n),
    .touch_key (touch_key),
    .MOSI      (MOSI),
    .cs_n      (cs_n),
    .sck       (sck)
  );

  always #10 sys_clk = ~sys_clk;

  typedef struct {
    logic [7:0] byte_v;
    bit         partial;
    bit         gap_chk;
  } exp_t;

  exp_t exp_q[$];
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic push_pair();
    exp_t e;
    e.byte_v = 8'h06; e.partial = 1'b0; e.gap_chk = 1'b0;
    exp_q.push_back(e);
    e.byte_v = 8'hC7; e.partial = 1'b0; e.gap_chk = 1'b1;
    exp_q.push_back(e);
  endtask

  // Monitor and flash model
  bit         in_win = 1'b0;
  int         rises, lowcyc, highcyc, gap_seen, win_count;
  logic [7:0] shreg;
  logic       prev_sck = 1'b0, prev_mosi = 1'b0;
  int         mode0_err = 0, idle_sck_err = 0, idle_mosi_err = 0;
  bit         wel = 1'b0, wip = 1'b0;

  initial begin
    rises = 0; lowcyc = 0; highcyc = 0; gap_seen = 0; win_count = 0; shreg = '0;
  end

  always @(negedge sys_clk) begin
    exp_t e;
    if (sck && prev_sck && (MOSI !== prev_mosi)) mode0_err++;
    if (cs_n === 1'b0) begin
      if (!in_win) begin
        in_win   = 1'b1;
        lowcyc   = 0;
        rises    = 0;
        shreg    = '0;
        gap_seen = highcyc;
      end
      lowcyc++;
      if (sck && !prev_sck) begin
        rises++;
        shreg = {shreg[6:0], MOSI};
      end
    end else begin
      if (sck !== 1'b0) idle_sck_err++;
      if (MOSI !== 1'b0) idle_mosi_err++;
      if (in_win) begin
        in_win = 1'b0;
        win_count++;
        highcyc = 0;
        if (rises == 8 && shreg == 8'h06) wel = 1'b1;
        if (rises == 8 && shreg == 8'hC7 && wel) begin
          wip = 1'b1;
          wel = 1'b0;
        end
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_window: got byte %0h with %0d sck rises, required no window", shreg, rises);
        end else begin
          e = exp_q.pop_front();
          if (e.partial) begin
            check("aborted_window_rises_below_8", 32'(rises < 8), 32'd1);
          end else begin
            check("cmd_byte", 32'(shreg), 32'(e.byte_v));
            check("sck_rises", 32'(rises), 32'd8);
            check("cs_low_cycles", 32'(lowcyc), 32'd36);
            if (e.gap_chk) check("cs_gap_cycles", 32'(gap_seen), 32'd8);
          end
        end
      end
      highcyc++;
    end
    prev_sck  = sck;
    prev_mosi = MOSI;
  end

  initial begin
    exp_t e;
    bit found;

    @(posedge sys_clk); #1;
    check("reset_cs_n", 32'(cs_n), 32'd1);
    check("reset_sck", 32'(sck), 32'd0);
    check("reset_mosi", 32'(MOSI), 32'd0);
    #9 rst_n = 1'b1;

    // First press: WREN then BE
    push_pair();
    #(520 - 20) touch_key = 1'b0;
    #500 touch_key = 1'b1;
    #(1350 - 1020);
    check("flash_wel_after_wren", 32'(wel), 32'd1);
    check("flash_wip_before_be", 32'(wip), 32'd0);

    // Press while busy is dropped
    #(1800 - 1350) touch_key = 1'b0;
    #200 touch_key = 1'b1;
    #(2300 - 2000);
    check("flash_wip_after_be", 32'(wip), 32'd1);
    check("idle_cs_n_after_seq", 32'(cs_n), 32'd1);
    check("idle_sck_after_seq", 32'(sck), 32'd0);
    check("windows_after_busy_press", 32'(win_count), 32'd2);

    // Press after completion re-issues the pair
    push_pair();
    #(47000 - 2300) touch_key = 1'b0;
    #200 touch_key = 1'b1;
    #(49000 - 47200);
    check("windows_after_third_press", 32'(win_count), 32'd4);

    // Held key gives a single sequence
    push_pair();
    #(50000 - 49000) touch_key = 1'b0;
    #10000 touch_key = 1'b1;
    #1000;
    check("windows_after_held_key", 32'(win_count), 32'd6);

    // Reset during WREN transmission
    e.byte_v = 8'h06; e.partial = 1'b1; e.gap_chk = 1'b0;
    exp_q.push_back(e);
    #(65000 - 61000) touch_key = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge sys_clk);
      if (cs_n === 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    check("reset_test_cs_fall_within_bound", 32'(found), 32'd1);
    touch_key = 1'b1;
    repeat (8) @(posedge sys_clk);
    @(negedge sys_clk) rst_n = 1'b0;
    @(posedge sys_clk); #1;
    check("midcmd_reset_cs_n", 32'(cs_n), 32'd1);
    check("midcmd_reset_sck", 32'(sck), 32'd0);
    check("midcmd_reset_mosi", 32'(MOSI), 32'd0);
    @(negedge sys_clk) rst_n = 1'b1;
    #5000;
    check("windows_after_reset_quiet", 32'(win_count), 32'd7);
    check("cs_n_idle_after_reset", 32'(cs_n), 32'd1);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check("mode0_mosi_stable_while_sck_high", 32'(mode0_err), 32'd0);
    check("sck_low_while_cs_high", 32'(idle_sck_err), 32'd0);
    check("mosi_low_while_cs_high", 32'(idle_mosi_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
